// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pkg
// Description : Shared widths, pooling FSM state encoding and size helpers
//               for the binary max-pool stage.
// Revision    : 1.0 - initial release
// ============================================================================
package bnn_pkg;

    localparam int c_DATA_W = 16;
    localparam int c_ADDR_W = 12;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_POOL = 3'd3,
        S_DONE = 3'd4
    } pool_state_t;

    // Odd trailing rows and columns are dropped by flooring.
    function automatic int pair_count(input int num_rows);
        return num_rows / 2;
    endfunction

    function automatic int out_width(input int row_w);
        return row_w / 2;
    endfunction

    function automatic logic win_or(input logic [3:0] win);
        return |win;
    endfunction

    function automatic logic win_maj(input logic [3:0] win);
        return $countones(win) >= 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_maxpool_if.sv
`default_nettype none
// ============================================================================
// Module      : bnn_maxpool_if
// Description : Run/busy handshake plus SRAM read/write port of the pool stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface bnn_maxpool_if
    import bnn_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) ();

    logic              run;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] dut_sram_read_address;
    logic [DATA_W-1:0] sram_dut_read_data;
    logic [ADDR_W-1:0] dut_sram_write_address;
    logic [DATA_W-1:0] dut_sram_write_data;
    logic              wr_enable;

    modport master (
        input  run,
        input  sram_dut_read_data,
        output busy,
        output done,
        output dut_sram_read_address,
        output dut_sram_write_address,
        output dut_sram_write_data,
        output wr_enable
    );

    modport slave (
        output run,
        output sram_dut_read_data,
        input  busy,
        input  done,
        input  dut_sram_read_address,
        input  dut_sram_write_address,
        input  dut_sram_write_data,
        input  wr_enable
    );

endinterface
`default_nettype wire

// File: rtl/bnn_pool_row.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pool_row
// Description : Combinational 2x2 stride-2 pooling of two binary rows.
//               BNN_POOL_AVG_EN selects 2-of-4 majority instead of OR.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_pool_row
    import bnn_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ROW_W  = 14
) (
    input  logic [DATA_W-1:0] row_a,
    input  logic [DATA_W-1:0] row_b,
    output logic [DATA_W-1:0] pooled
);

    localparam int c_OUT_W = out_width(ROW_W);

    always_comb begin
        pooled = '0;
        for (int j = 0; j < DATA_W / 2; j++) begin
            if (j < c_OUT_W) begin
`ifdef BNN_POOL_AVG_EN
                pooled[j] = win_maj({row_a[2*j+1], row_a[2*j], row_b[2*j+1], row_b[2*j]});
`else
                pooled[j] = win_or({row_a[2*j+1], row_a[2*j], row_b[2*j+1], row_b[2*j]});
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bnn_maxpool.sv
`default_nettype none
// ============================================================================
// Module      : bnn_maxpool
// Description : Reads row pairs from SRAM, pools them and writes one output
//               row per pair (3 cycles/row). Pool mode via BNN_POOL_AVG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_maxpool
    import bnn_pkg::*;
#(
    parameter int                DATA_W   = c_DATA_W,
    parameter int                ADDR_W   = c_ADDR_W,
    parameter int                ROW_W    = 14,
    parameter int                NUM_ROWS = 14,
    parameter logic [ADDR_W-1:0] SRC_BASE = '0,
    parameter logic [ADDR_W-1:0] DST_BASE = ADDR_W'('h100)
) (
    input  logic          clk,
    input  logic          reset,
    bnn_maxpool_if.master bus
);

    localparam int                c_NPAIR     = pair_count(NUM_ROWS);
    localparam logic [ADDR_W-1:0] c_LAST_PAIR = ADDR_W'(c_NPAIR - 1);

    pool_state_t       r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pair, w_pair_nxt;
    logic [DATA_W-1:0] r_row_a, w_row_a_nxt;
    logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [DATA_W-1:0] r_wr_data, w_wr_data_nxt;
    logic              r_wr_en, w_wr_en_nxt;
    logic [DATA_W-1:0] w_pooled;

    // Row B is consumed straight off the read bus in POOL, saving a cycle.
    bnn_pool_row #(
        .DATA_W (DATA_W),
        .ROW_W  (ROW_W)
    ) u_pool_row (
        .row_a  (r_row_a),
        .row_b  (bus.sram_dut_read_data),
        .pooled (w_pooled)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pair    <= '0;
            r_row_a   <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_en   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pair    <= w_pair_nxt;
            r_row_a   <= w_row_a_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_wr_en   <= w_wr_en_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pair_nxt    = r_pair;
        w_row_a_nxt   = r_row_a;
        w_rd_addr_nxt = r_rd_addr;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_wr_en_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.run) begin
                    w_pair_nxt = '0;
                    if (c_NPAIR == 0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt   = S_RD_A;
                        w_rd_addr_nxt = SRC_BASE;
                    end
                end
            end
            S_RD_A: begin
                w_state_nxt   = S_RD_B;
                w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
            end
            S_RD_B: begin
                w_row_a_nxt = bus.sram_dut_read_data;
                w_state_nxt = S_POOL;
            end
            S_POOL: begin
                w_wr_addr_nxt = DST_BASE + r_pair;
                w_wr_data_nxt = w_pooled;
                w_wr_en_nxt   = 1'b1;
                if (r_pair == c_LAST_PAIR) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_pair_nxt    = r_pair + ADDR_W'(1);
                    w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
                    w_state_nxt   = S_RD_A;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.busy                   = (r_state != S_IDLE);
    assign bus.done                   = (r_state == S_DONE);
    assign bus.dut_sram_read_address  = r_rd_addr;
    assign bus.dut_sram_write_address = r_wr_addr;
    assign bus.dut_sram_write_data    = r_wr_data;
    assign bus.wr_enable              = r_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_bnn_maxpool.sv
`default_nettype none
// ============================================================================
// Module      : tb_bnn_maxpool
// Description : Self-checking bench for bnn_maxpool: three sizings, SRAM
//               models and a bit-counting reference pool model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_maxpool;

    typedef struct {
        int          idx;
        logic [11:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [15:0] src [3][0:15];
    int          t0 [3];
    int          done_cnt [3];
    int          done_cyc [3];
    int          max_rd1;
    wr_t         wlog [$];

    bnn_maxpool_if #(.DATA_W(16), .ADDR_W(12)) bus0 ();
    bnn_maxpool_if #(.DATA_W(16), .ADDR_W(12)) bus1 ();
    bnn_maxpool_if #(.DATA_W(16), .ADDR_W(12)) bus2 ();

    bnn_maxpool u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    bnn_maxpool #(.ROW_W(13), .NUM_ROWS(5)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    bnn_maxpool #(.NUM_ROWS(1)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models: one-cycle read latency, only rows 0..15 populated
    always @(posedge clk) begin
        bus0.sram_dut_read_data <= (bus0.dut_sram_read_address < 12'd16) ? src[0][bus0.dut_sram_read_address[3:0]] : 16'h0;
        bus1.sram_dut_read_data <= (bus1.dut_sram_read_address < 12'd16) ? src[1][bus1.dut_sram_read_address[3:0]] : 16'h0;
        bus2.sram_dut_read_data <= (bus2.dut_sram_read_address < 12'd16) ? src[2][bus2.dut_sram_read_address[3:0]] : 16'h0;
    end

    task automatic mon(input int idx, input logic we, input logic [11:0] wa, input logic [15:0] wd, input logic dn);
        if (we) wlog.push_back('{idx, wa, wd, cyc - t0[idx]});
        if (dn) begin
            done_cnt[idx]++;
            done_cyc[idx] = cyc - t0[idx];
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.wr_enable, bus0.dut_sram_write_address, bus0.dut_sram_write_data, bus0.done);
        mon(1, bus1.wr_enable, bus1.dut_sram_write_address, bus1.dut_sram_write_data, bus1.done);
        mon(2, bus2.wr_enable, bus2.dut_sram_write_address, bus2.dut_sram_write_data, bus2.done);
        if (bus1.busy && int'(bus1.dut_sram_read_address) > max_rd1) max_rd1 = int'(bus1.dut_sram_read_address);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference pool: count ones in each 2x2 window.
    function automatic logic [15:0] ref_pool(input logic [15:0] a, input logic [15:0] b, input int row_w);
        logic [15:0] r;
        int          n;
        r = '0;
        for (int j = 0; j < row_w / 2; j++) begin
            n = int'(a[2*j]) + int'(a[2*j+1]) + int'(b[2*j]) + int'(b[2*j+1]);
`ifdef BNN_POOL_AVG_EN
            r[j] = (n >= 2);
`else
            r[j] = (n >= 1);
`endif
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic set_run(input int idx, input logic v);
        case (idx)
            0:       bus0.run = v;
            1:       bus1.run = v;
            default: bus2.run = v;
        endcase
    endtask

    function automatic logic busy_of(input int idx);
        case (idx)
            0:       return bus0.busy;
            1:       return bus1.busy;
            default: return bus2.busy;
        endcase
    endfunction

    task automatic start_job(input int idx, input bit hold);
        wlog.delete();
        done_cnt[idx] = 0;
        done_cyc[idx] = -1;
        max_rd1       = 0;
        set_run(idx, 1'b1);
        @(posedge clk);
        t0[idx] = cyc;
        tick();
        if (!hold) set_run(idx, 1'b0);
        check_eq("busy_cycle1", {31'd0, busy_of(idx)}, 32'd1);
    endtask

    task automatic wait_done(input int idx);
        int waited;
        waited = 0;
        while (done_cnt[idx] == 0 && waited < 300) begin
            tick();
            waited++;
        end
        check_eq("done_seen", done_cnt[idx], 1);
    endtask

    task automatic finish_job(input int idx, input int np, input int row_w);
        wr_t got [$];
        wait_done(idx);
        check_eq("done_cycle", done_cyc[idx], 3 * np + 1);
        tick();
        check_eq("busy_after_done", {31'd0, busy_of(idx)}, 32'd0);
        repeat (8) tick();
        check_eq("done_count", done_cnt[idx], 1);
        foreach (wlog[i]) if (wlog[i].idx == idx) got.push_back(wlog[i]);
        check_eq("wr_count", got.size(), np);
        for (int k = 0; k < got.size() && k < np; k++) begin
            check_eq("wr_addr", got[k].addr, 32'h100 + k);
            check_eq("wr_data", got[k].data, ref_pool(src[idx][2*k], src[idx][2*k+1], row_w));
            check_eq("wr_cycle", got[k].cyc, 4 + 3 * k);
        end
    endtask

    task automatic fill(input int idx, input int mode);
        for (int r = 0; r < 16; r++) begin
            case (mode)
                0:       src[idx][r] = 16'h0;
                1:       src[idx][r] = (r % 2 == 0) ? 16'h0001 : 16'h0000;
                2:       src[idx][r] = 16'hFFFF;
                default: src[idx][r] = 16'($urandom);
            endcase
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus0.run = 1'b0;
        bus1.run = 1'b0;
        bus2.run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fill(i, 0);
            t0[i]       = 0;
            done_cnt[i] = 0;
            done_cyc[i] = -1;
        end
        max_rd1 = 0;
        repeat (3) tick();
        check_eq("rst_busy", {31'd0, bus0.busy}, 32'd0);
        check_eq("rst_done", {31'd0, bus0.done}, 32'd0);
        check_eq("rst_wr_en", {31'd0, bus0.wr_enable}, 32'd0);
        check_eq("rst_rd_addr", bus0.dut_sram_read_address, 32'd0);
        check_eq("rst_wr_addr", bus0.dut_sram_write_address, 32'd0);
        check_eq("rst_wr_data", bus0.dut_sram_write_data, 32'd0);
        reset = 1'b0;
        tick();

        // alternating 0001/0000 rows
        fill(0, 1);
        start_job(0, 0);
        finish_job(0, 7, 14);

        // column/row coverage of the OR window
        fill(0, 0);
        src[0][0] = 16'h2000;
        src[0][1] = 16'h0002;
        start_job(0, 0);
        finish_job(0, 7, 14);

        // 1-of-4 vs 2-of-4 windows
        fill(0, 0);
        src[0][0] = 16'h0001;
        src[0][2] = 16'h0003;
        start_job(0, 0);
        finish_job(0, 7, 14);

        for (int n = 0; n < 3; n++) begin
            fill(0, 3);
            start_job(0, 0);
            finish_job(0, 7, 14);
        end

        // odd row width / odd row count
        fill(1, 2);
        start_job(1, 0);
        finish_job(1, 2, 13);
        check_eq("max_read_addr", max_rd1, 3);
        fill(1, 3);
        start_job(1, 0);
        finish_job(1, 2, 13);
        check_eq("max_read_addr_rand", max_rd1, 3);

        // fewer than two rows: done only
        start_job(2, 0);
        finish_job(2, 0, 14);

        // run pulsed during busy is ignored
        fill(0, 3);
        start_job(0, 0);
        repeat (4) tick();
        set_run(0, 1'b1);
        tick();
        set_run(0, 1'b0);
        finish_job(0, 7, 14);

        // run held high restarts one cycle after DONE
        fill(0, 3);
        start_job(0, 1);
        wait_done(0);
        check_eq("hold_done_cycle", done_cyc[0], 22);
        tick();
        check_eq("hold_idle_busy", {31'd0, bus0.busy}, 32'd0);
        tick();
        check_eq("hold_restart_busy", {31'd0, bus0.busy}, 32'd1);
        check_eq("hold_restart_addr", bus0.dut_sram_read_address, 32'd0);
        set_run(0, 1'b0);
        for (int w = 0; w < 60 && bus0.busy; w++) tick();
        check_eq("hold_second_end", {31'd0, bus0.busy}, 32'd0);

        // asynchronous reset mid-run, then a clean job
        fill(0, 3);
        start_job(0, 0);
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check_eq("midrst_busy", {31'd0, bus0.busy}, 32'd0);
        check_eq("midrst_wr_en", {31'd0, bus0.wr_enable}, 32'd0);
        check_eq("midrst_rd_addr", bus0.dut_sram_read_address, 32'd0);
        check_eq("midrst_wr_addr", bus0.dut_sram_write_address, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        fill(0, 3);
        start_job(0, 0);
        finish_job(0, 7, 14);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
